pingpong_frame_buf: RTL
=======================

Name: pingpong_frame_buf

Overview:
- Single-clock, parametrised ping-pong frame buffer with two internal banks.
- A producer writes whole frames into one bank while a consumer drains the other bank. Frames are delimited by last markers.
- Both sides use valid/ready handshakes. Frame order is preserved.
- Sits between a bursty packet source and a downstream stream consumer. It generalises the earlier fixed-width, fixed-length dual-RAM buffer with variable frame length, a truncation flag and backpressure.

Parameters:
- DATA_W, 8: data width of both ports.
- ADDR_W, 4: bank address width.
- DEPTH, 2**ADDR_W: words per bank, i.e. the maximum stored frame length.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear, highest priority after reset.
- s_data  in  DATA_W  write data.
- s_valid  in  1  write beat valid.
- s_last  in  1  final beat of the frame.
- s_ready  out  1  write beat accepted when s_valid && s_ready.
- m_data  out  DATA_W  read data, registered.
- m_valid  out  1  read beat valid.
- m_last  out  1  final beat of the frame.
- m_err  out  1  frame was truncated; meaningful only on the m_last beat.
- m_len  out  ADDR_W+1  stored length of the current frame, stable while the frame drains.
- m_ready  in  1  consumer accepts the beat.
- bank_full  out  2  per-bank FULL/DRAINING status.
- drop_pulse  out  1  frame-dropped strobe.

Behaviour:
- Reset and flush:
  - rst_n low (asynchronous) or flush high (synchronous) sets both banks EMPTY, wsel=0, rsel=0 and all counters to 0.
  - All outputs go to 0 except s_ready, which is 1. Stored data is discarded.
  - Assertion mid-frame abandons the frame; no partial output is produced.
- Bank states: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
- Write side:
  - s_ready = 1 when bank[wsel] is EMPTY or FILLING, or when the discard mode below is active.
  - Each accepted beat is stored at wcnt, then wcnt increments.
  - An accept with s_last, or an accept at wcnt==DEPTH-1, closes the bank:
    - the bank becomes FULL;
    - len[wsel] = wcnt+1;
    - wsel toggles;
    - wcnt returns to 0.
  - Overlength frame: if the accept at wcnt==DEPTH-1 is not s_last, the bank closes with trunc=1. The writer then enters discard mode: s_ready=1 and beats are dropped up to and including s_last, after which normal writing resumes on the new wsel.
  - A 1-beat frame stores len=1. No zero-length frames exist.
- Read side:
  - The output register loads when (!m_valid || m_ready) and bank[rsel] is FULL or DRAINING with beats remaining.
  - Memory read is synchronous into m_data/m_last/m_err.
  - m_valid rises 2 cycles after the closing write handshake (cycle N accept -> FULL at N+1 -> m_valid at N+2).
  - Once m_valid is asserted, every handshake can be followed by the next beat in the next cycle (full throughput).
  - m_data, m_last and m_err are held stable while m_valid && !m_ready.
  - When the last word of a bank is loaded into the output register, the bank returns to EMPTY in the next cycle and rsel toggles.
  - m_len is latched when the first word of a frame is loaded.
- Concurrency:
  - Write and read on different banks are fully independent.
  - The writer never enters a bank that is not EMPTY; s_ready=0 until it frees.
  - A bank freeing and the writer's next accept in the same cycle: the accept is taken in the following cycle (no bypass).
- bank_full[i]=1 while bank i is FULL or DRAINING.

Optional Feature:
- Macro: PP_FRAME_BUF_DROP_EN.
- Defined: if the first beat of a frame arrives while bank[wsel] is not EMPTY, the whole frame is discarded.
  - s_ready is held 1 through s_last.
  - drop_pulse is high for one cycle on the accepted s_last beat.
  - Stored frames are unaffected.
- Undefined: s_ready backpressures as above and drop_pulse is tied to 0.

Test Plan:
- Reset/flush: assert rst_n=0 mid-drain, then release; repeat with a flush pulse. Required: m_valid=0, bank_full=2'b00, s_ready=1, and no residual beats emerge afterwards.
- Single frame: 4 beats 0x10..0x13 with s_last on 0x13 and m_ready=1. Required: m_valid rises 2 cycles after the 0x13 accept; output is 0x10..0x13 consecutively with m_last on 0x13; m_len=4; m_err=0.
- Ping-pong full: three back-to-back 16-beat frames (0x00.., 0x40.., 0x80..) with m_ready=0.
  - Required: 32 beats accepted, then s_ready=0 and bank_full=2'b11.
  - Then raise m_ready. Required: the frames emerge in order, and the third frame is accepted once bank 0 frees.
- Overlength: a 20-beat frame (0x00..0x13). Required: s_ready stays 1 throughout; output is 16 beats 0x00..0x0F, m_len=16, m_err=1 on 0x0F.
- Read backpressure: a 16-beat frame with m_ready toggling in a pseudo-random pattern. Required: m_data stable whenever m_valid && !m_ready; all 16 values appear exactly once, in order.
- Drop mode: fill both banks, then send a 5-beat frame.
  - Macro undefined: s_ready=0 until a bank frees.
  - Macro defined: 5 beats accepted, drop_pulse=1 for exactly the 5th beat cycle, and the two stored frames are output unchanged.

Source files
------------

// File: rtl/pingpong_frame_buf.sv
// pingpong_frame_buf: two-bank ping-pong frame buffer, valid/ready on both sides.
// The producer fills one bank with a whole frame while the consumer drains the other.
// Frames longer than a bank are truncated and flagged; their tail beats are discarded.
// Optional macro PP_FRAME_BUF_DROP_EN: a frame whose first beat arrives while the write
// bank is still occupied is accepted and discarded (drop_pulse on its last beat) instead
// of being backpressured.
module pingpong_frame_buf #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  output logic              m_err,
  output logic [ADDR_W:0]   m_len,
  input  logic              m_ready,
  output logic [1:0]        bank_full,
  output logic              drop_pulse
);

  localparam int unsigned LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'b00,
    ST_FILLING  = 2'b01,
    ST_FULL     = 2'b10,
    ST_DRAINING = 2'b11
  } bank_st_t;

  bank_st_t          r_bst [2];
  logic              r_wsel;
  logic              r_rsel;
  logic [ADDR_W-1:0] r_wcnt;
  logic [LEN_W-1:0]  r_rcnt;
  logic [LEN_W-1:0]  r_len [2];
  logic [1:0]        r_trunc;
  logic              r_disc;
  logic [DATA_W-1:0] r_mem [2][DEPTH];

  logic [DATA_W-1:0] r_m_data;
  logic              r_m_valid;
  logic              r_m_last;
  logic              r_m_err;
  logic [LEN_W-1:0]  r_m_len;

  logic w_wr_open;
  logic w_drop_cond;
  logic w_s_acc;
  logic w_wr;
  logic w_wr_close;
  logic w_rd_avail;
  logic w_rd_load;
  logic w_rd_final;

  // Write side: the writer may only enter an EMPTY bank or continue a FILLING one.
  assign w_wr_open  = (r_bst[r_wsel] == ST_EMPTY) || (r_bst[r_wsel] == ST_FILLING);
  assign s_ready    = r_disc || w_wr_open || w_drop_cond;
  assign w_s_acc    = s_valid && s_ready;
  assign w_wr       = w_s_acc && !r_disc && w_wr_open;
  assign w_wr_close = w_wr && (s_last || (r_wcnt == ADDR_W'(DEPTH - 1)));

  // Read side: load the output register whenever it is free or being consumed.
  assign w_rd_avail = ((r_bst[r_rsel] == ST_FULL) || (r_bst[r_rsel] == ST_DRAINING)) &&
                      (r_rcnt < r_len[r_rsel]);
  assign w_rd_load  = (!r_m_valid || m_ready) && w_rd_avail;
  assign w_rd_final = w_rd_load && ((r_rcnt + 1'b1) == r_len[r_rsel]);

  assign m_data    = r_m_data;
  assign m_valid   = r_m_valid;
  assign m_last    = r_m_last;
  assign m_err     = r_m_err;
  assign m_len     = r_m_len;
  assign bank_full = {(r_bst[1] == ST_FULL) || (r_bst[1] == ST_DRAINING),
                      (r_bst[0] == ST_FULL) || (r_bst[0] == ST_DRAINING)};

`ifdef PP_FRAME_BUF_DROP_EN
  logic r_drop;

  // A first beat hitting an occupied bank starts a whole-frame drop.
  assign w_drop_cond = !r_disc && !w_wr_open;
  assign drop_pulse  = w_s_acc && s_last && (w_drop_cond || (r_disc && r_drop));

  // Remembers that the current discard is a dropped frame rather than an overlength tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop <= 1'b0;
    end else if (flush) begin
      r_drop <= 1'b0;
    end else if (w_s_acc && w_drop_cond && !s_last) begin
      r_drop <= 1'b1;
    end else if (w_s_acc && r_disc && s_last) begin
      r_drop <= 1'b0;
    end
  end
`else
  assign w_drop_cond = 1'b0;
  assign drop_pulse  = 1'b0;
`endif

  // Frame storage; contents need no reset because bank states gate every read.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wsel][r_wcnt] <= s_data;
    end
  end

  // Bank state machine, write/read pointers and the registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bst[0]  <= ST_EMPTY;
      r_bst[1]  <= ST_EMPTY;
      r_wsel    <= 1'b0;
      r_rsel    <= 1'b0;
      r_wcnt    <= '0;
      r_rcnt    <= '0;
      r_len[0]  <= '0;
      r_len[1]  <= '0;
      r_trunc   <= '0;
      r_disc    <= 1'b0;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_err   <= 1'b0;
      r_m_len   <= '0;
    end else if (flush) begin
      r_bst[0]  <= ST_EMPTY;
      r_bst[1]  <= ST_EMPTY;
      r_wsel    <= 1'b0;
      r_rsel    <= 1'b0;
      r_wcnt    <= '0;
      r_rcnt    <= '0;
      r_len[0]  <= '0;
      r_len[1]  <= '0;
      r_trunc   <= '0;
      r_disc    <= 1'b0;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_err   <= 1'b0;
      r_m_len   <= '0;
    end else begin
      // Writer: store a beat, or close the bank on s_last / bank capacity.
      if (w_wr) begin
        r_bst[r_wsel] <= ST_FILLING;
        r_wcnt        <= r_wcnt + 1'b1;
        if (w_wr_close) begin
          r_bst[r_wsel]   <= ST_FULL;
          r_len[r_wsel]   <= LEN_W'(r_wcnt) + LEN_W'(1);
          r_trunc[r_wsel] <= !s_last;
          r_wsel          <= !r_wsel;
          r_wcnt          <= '0;
          r_disc          <= !s_last;
        end
      end else if (w_s_acc) begin
        // Discarded beat: overlength tail or dropped frame, ends on s_last.
        r_disc <= !s_last;
      end

      // Reader: the bank being drained is never the one being written.
      if (w_rd_load) begin
        r_m_data  <= r_mem[r_rsel][r_rcnt[ADDR_W-1:0]];
        r_m_valid <= 1'b1;
        r_m_last  <= w_rd_final;
        r_m_err   <= w_rd_final && r_trunc[r_rsel];
        if (r_rcnt == '0) begin
          r_m_len <= r_len[r_rsel];
        end
        if (w_rd_final) begin
          r_bst[r_rsel] <= ST_EMPTY;
          r_rsel        <= !r_rsel;
          r_rcnt        <= '0;
        end else begin
          r_bst[r_rsel] <= ST_DRAINING;
          r_rcnt        <= r_rcnt + 1'b1;
        end
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

endmodule
